// File: rtl/state_serializer.sv
// Streams a captured 4x4 AES state column-major as raw bytes or as
// uppercase ASCII hex pairs, with a valid/ready handshake on both sides.
module state_serializer #(
    parameter int HEX_ASCII = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   state_in [0:3][0:3],
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [127:0] block_word,
    output logic         busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    localparam bit HEX = (HEX_ASCII != 0);

    logic [0:0]   state;
    logic [3:0]   idx;
    logic         nib;
    logic [7:0]   data_buf [0:15];
    logic [127:0] packed_in;
    logic [7:0]   cur_byte;
    logic [3:0]   cur_nib;
    logic [7:0]   hex_char;
    logic         sending;
    logic         fire;
    logic         last_beat;

    // Buffer is kept in stream order so idx addresses it directly.
    always_comb begin
        packed_in = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                packed_in[127 - 8*(4*c + r) -: 8] = state_in[r][c];
            end
        end
    end

    always_comb begin
        sending   = (state == SEND);
        cur_byte  = data_buf[idx];
        cur_nib   = nib ? cur_byte[3:0] : cur_byte[7:4];
        if (cur_nib < 4'd10) begin
            hex_char = 8'h30 + {4'h0, cur_nib};
        end else begin
            hex_char = 8'h37 + {4'h0, cur_nib};
        end
        last_beat = HEX ? ((idx == 4'd15) && nib) : (idx == 4'd15);
        fire      = sending && out_ready;
    end

    always_comb begin
        in_ready  = !sending;
        out_valid = sending;
        busy      = sending;
        out_last  = sending && last_beat;
        out_data  = 8'h00;
        if (sending) begin
            out_data = HEX ? hex_char : cur_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            nib        <= 1'b0;
            block_word <= '0;
            for (int k = 0; k < 16; k++) begin
                data_buf[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state      <= SEND;
                        idx        <= '0;
                        nib        <= 1'b0;
                        block_word <= packed_in;
                        for (int k = 0; k < 16; k++) begin
                            data_buf[k] <= packed_in[127 - 8*k -: 8];
                        end
                    end
                end
                SEND: begin
                    if (fire) begin
                        if (HEX) begin
                            nib <= ~nib;
                            if (nib) begin
                                idx <= idx + 4'd1;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_serializer.sv
// Bench for state_serializer: raw and hex instances side by side, checked
// every cycle against a queue model plus hand-computed stream literals.
module tb_state_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [7:0]   st [0:3][0:3];

    logic         in_ready_r, out_valid_r, out_last_r, busy_r;
    logic [7:0]   out_data_r;
    logic [127:0] bw_r;
    logic         in_ready_h, out_valid_h, out_last_h, busy_h;
    logic [7:0]   out_data_h;
    logic [127:0] bw_h;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    logic [7:0]   q_r[$];
    logic [7:0]   q_h[$];
    logic [7:0]   seen_r[$];
    logic [7:0]   seen_h[$];
    logic [127:0] mbw_r = '0;
    logic [127:0] mbw_h = '0;
    logic [7:0]   mb;

    localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;

    state_serializer #(.HEX_ASCII(0)) u_raw (
        .clk(clk), .rst_n(rst_n), .state_in(st), .in_valid(in_valid),
        .in_ready(in_ready_r), .out_data(out_data_r), .out_valid(out_valid_r),
        .out_ready(out_ready), .out_last(out_last_r), .block_word(bw_r),
        .busy(busy_r)
    );

    state_serializer #(.HEX_ASCII(1)) u_hex (
        .clk(clk), .rst_n(rst_n), .state_in(st), .in_valid(in_valid),
        .in_ready(in_ready_h), .out_data(out_data_h), .out_valid(out_valid_h),
        .out_ready(out_ready), .out_last(out_last_h), .block_word(bw_h),
        .busy(busy_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    // Model: each instance owns a queue of the characters still to send.
    always @(negedge clk) begin
        if (armed) begin
            chk("raw_valid", 128'(out_valid_r), 128'(q_r.size() != 0));
            chk("raw_last", 128'(out_last_r), 128'(q_r.size() == 1));
            chk("raw_in_ready", 128'(in_ready_r), 128'(q_r.size() == 0));
            chk("raw_busy", 128'(busy_r), 128'(q_r.size() != 0));
            chk("raw_block_word", bw_r, mbw_r);
            if (q_r.size() != 0) chk("raw_data", 128'(out_data_r), 128'(q_r[0]));
            chk("hex_valid", 128'(out_valid_h), 128'(q_h.size() != 0));
            chk("hex_last", 128'(out_last_h), 128'(q_h.size() == 1));
            chk("hex_in_ready", 128'(in_ready_h), 128'(q_h.size() == 0));
            chk("hex_busy", 128'(busy_h), 128'(q_h.size() != 0));
            chk("hex_block_word", bw_h, mbw_h);
            if (q_h.size() != 0) chk("hex_data", 128'(out_data_h), 128'(q_h[0]));
        end
        if (!rst_n) begin
            q_r.delete();
            q_h.delete();
            mbw_r = '0;
            mbw_h = '0;
            armed = 1'b1;
        end else begin
            if (out_valid_r && out_ready) seen_r.push_back(out_data_r);
            if (out_valid_h && out_ready) seen_h.push_back(out_data_h);
            if (q_r.size() == 0) begin
                if (in_valid) begin
                    for (int k = 0; k < 16; k++) begin
                        mb = st[k % 4][k / 4];
                        q_r.push_back(mb);
                        mbw_r[127 - 8*k -: 8] = mb;
                    end
                end
            end else if (out_ready) begin
                void'(q_r.pop_front());
            end
            if (q_h.size() == 0) begin
                if (in_valid) begin
                    for (int k = 0; k < 16; k++) begin
                        mb = st[k % 4][k / 4];
                        q_h.push_back(asc(mb[7:4]));
                        q_h.push_back(asc(mb[3:0]));
                        mbw_h[127 - 8*k -: 8] = mb;
                    end
                end
            end else if (out_ready) begin
                void'(q_h.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_state(input logic [127:0] w);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                st[r][c] = w[127 - 8*(4*c + r) -: 8];
            end
        end
    endtask

    task automatic send_block(input logic [127:0] w);
        set_state(w);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready_r && in_ready_h) done = 1'b1;
            else tick();
        end
        chk(nm, 128'(done), 128'(1));
    endtask

    task automatic clear_seen();
        seen_r.delete();
        seen_h.delete();
    endtask

    initial begin
        set_state('0);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 128'(in_ready_r), 128'(1));
        chk("rst_out_valid", 128'(out_valid_r), 128'(0));
        chk("rst_out_last", 128'(out_last_r), 128'(0));
        chk("rst_busy", 128'(busy_r), 128'(0));
        chk("rst_out_data", 128'(out_data_r), 128'(0));
        chk("rst_block_word", bw_r, 128'(0));

        clear_seen();
        send_block(BLK_A);
        wait_idle("raw_timeout");
        chk("raw_count", 128'(seen_r.size()), 128'(16));
        chk("raw_b0", 128'(seen_r[0]), 128'h69);
        chk("raw_b1", 128'(seen_r[1]), 128'hc4);
        chk("raw_b2", 128'(seen_r[2]), 128'he0);
        chk("raw_b15", 128'(seen_r[15]), 128'h5a);
        chk("raw_word", bw_r, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("hex_count", 128'(seen_h.size()), 128'(32));
        chk("hex_c0", 128'(seen_h[0]), 128'h36);
        chk("hex_c1", 128'(seen_h[1]), 128'h39);
        chk("hex_c2", 128'(seen_h[2]), 128'h43);
        chk("hex_c3", 128'(seen_h[3]), 128'h34);
        chk("hex_c30", 128'(seen_h[30]), 128'h35);
        chk("hex_c31", 128'(seen_h[31]), 128'h41);
        chk("hex_word", bw_h, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        clear_seen();
        send_block(BLK_A);
        repeat (6) tick();
        chk("bp_at6", 128'(out_data_r), 128'h04);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 128'(out_data_r), 128'h04);
            chk("bp_hold_valid", 128'(out_valid_r), 128'(1));
        end
        out_ready = 1'b1;
        wait_idle("bp_timeout");
        chk("bp_count", 128'(seen_r.size()), 128'(16));
        chk("bp_b6", 128'(seen_r[6]), 128'h04);
        chk("bp_b7", 128'(seen_r[7]), 128'h30);
        chk("bp_b15", 128'(seen_r[15]), 128'h5a);
        chk("bp_hex_count", 128'(seen_h.size()), 128'(32));

        clear_seen();
        send_block(BLK_A);
        repeat (3) tick();
        set_state(BLK_B);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("ign_in_ready", 128'(in_ready_r), 128'(0));
            tick();
        end
        in_valid = 1'b0;
        wait_idle("ign_timeout");
        chk("ign_word", bw_r, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("ign_count", 128'(seen_r.size()), 128'(16));
        chk("ign_b10", 128'(seen_r[10]), 128'hb7);

        clear_seen();
        send_block(BLK_A);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_valid", 128'(out_valid_r), 128'(0));
        chk("mrst_in_ready", 128'(in_ready_r), 128'(1));
        chk("mrst_hex_valid", 128'(out_valid_h), 128'(0));
        chk("mrst_word", bw_r, 128'(0));
        chk("mrst_sent", 128'(seen_r.size()), 128'(10));
        tick();
        clear_seen();
        send_block(BLK_B);
        wait_idle("mrst_timeout");
        chk("mrst_count", 128'(seen_r.size()), 128'(16));
        chk("mrst_b0", 128'(seen_r[0]), 128'h00);
        chk("mrst_b1", 128'(seen_r[1]), 128'h11);
        chk("mrst_b15", 128'(seen_r[15]), 128'hff);
        chk("mrst_hex_c1", 128'(seen_h[1]), 128'h30);
        chk("mrst_hex_c31", 128'(seen_h[31]), 128'h46);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
